// File: rtl/ecc_op_scheduler.sv
// In-order op queue feeding the shared modular add/sub units and modulus register.
// One op is in flight at a time; each op yields exactly one result, and a hung unit is cut off by a watchdog.
module ecc_op_scheduler #(
  parameter int DEPTH      = 4,
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int TIMEOUT    = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [ID_WIDTH-1:0]   issue_id_i,
  input  logic [2:0]            issue_funct3_i,
  input  logic [4:0]            issue_rd_i,
  input  logic [DATA_WIDTH-1:0] issue_rs1_i,
  input  logic [DATA_WIDTH-1:0] issue_rs2_i,
  output logic                  add_start_o,
  output logic [DATA_WIDTH-1:0] add_a_o,
  output logic [DATA_WIDTH-1:0] add_b_o,
  input  logic                  add_finish_i,
  input  logic [DATA_WIDTH-1:0] add_result_i,
  output logic                  sub_start_o,
  output logic [DATA_WIDTH-1:0] sub_a_o,
  output logic [DATA_WIDTH-1:0] sub_b_o,
  input  logic                  sub_finish_i,
  input  logic [DATA_WIDTH-1:0] sub_result_i,
  output logic                  mod_write_o,
  output logic [DATA_WIDTH-1:0] mod_value_o,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic [ID_WIDTH-1:0]   result_id_o,
  output logic [4:0]            result_rd_o,
  output logic                  result_we_o,
  output logic                  result_exc_o,
  output logic [DATA_WIDTH-1:0] result_data_o,
  output logic                  busy_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, MOD_WR, WAIT_ADD, WAIT_SUB, RESP} state_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [2:0]            funct3;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] rs1;
    logic [DATA_WIDTH-1:0] rs2;
  } entry_t;

  entry_t mem_q [DEPTH];
  entry_t issue_entry;
  entry_t head;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  state_t                state_q, state_d;
  logic [WW-1:0]         wd_q, wd_d;
  logic [ID_WIDTH-1:0]   exec_id_q, exec_id_d;
  logic [4:0]            exec_rd_q, exec_rd_d;
  logic                  add_start_q, add_start_d, sub_start_q, sub_start_d;
  logic [DATA_WIDTH-1:0] add_a_q, add_a_d, add_b_q, add_b_d;
  logic [DATA_WIDTH-1:0] sub_a_q, sub_a_d, sub_b_q, sub_b_d;
  logic                  mod_write_q, mod_write_d;
  logic [DATA_WIDTH-1:0] mod_value_q, mod_value_d;
  logic                  res_valid_q, res_valid_d;
  logic [ID_WIDTH-1:0]   res_id_q, res_id_d;
  logic [4:0]            res_rd_q, res_rd_d;
  logic                  res_we_q, res_we_d, res_exc_q, res_exc_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;

  assign issue_ready_o = (count_q != CW'(DEPTH));
  assign busy_o        = (count_q != '0) || (state_q != IDLE);

  always_comb begin
    issue_entry.id     = issue_id_i;
    issue_entry.funct3 = issue_funct3_i;
    issue_entry.rd     = issue_rd_i;
    issue_entry.rs1    = issue_rs1_i;
    issue_entry.rs2    = issue_rs2_i;
    head = mem_q[rd_ptr_q];
    // Full blocks the push even when a pop frees a slot on the same edge.
    push = issue_valid_i && issue_ready_o;
    pop  = (state_q == IDLE) && (count_q != '0);
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= issue_entry;
  end

  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    exec_id_d   = exec_id_q;
    exec_rd_d   = exec_rd_q;
    add_start_d = add_start_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    sub_start_d = sub_start_q;
    sub_a_d     = sub_a_q;
    sub_b_d     = sub_b_q;
    mod_write_d = mod_write_q;
    mod_value_d = mod_value_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_rd_d    = res_rd_q;
    res_we_d    = res_we_q;
    res_exc_d   = res_exc_q;
    res_data_d  = res_data_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          exec_id_d = head.id;
          exec_rd_d = head.rd;
          wd_d      = '0;
          unique case (head.funct3)
            3'b000: begin
              mod_write_d = 1'b1;
              mod_value_d = head.rs1;
              state_d     = MOD_WR;
            end
            3'b001: begin
              add_start_d = 1'b1;
              add_a_d     = head.rs1;
              add_b_d     = head.rs2;
              state_d     = WAIT_ADD;
            end
            3'b010: begin
              sub_start_d = 1'b1;
              sub_a_d     = head.rs1;
              sub_b_d     = head.rs2;
              state_d     = WAIT_SUB;
            end
            default: begin
              res_valid_d = 1'b1;
              res_id_d    = head.id;
              res_rd_d    = head.rd;
              res_we_d    = 1'b0;
              res_exc_d   = 1'b0;
              res_data_d  = '0;
              state_d     = RESP;
            end
          endcase
        end
      end
      MOD_WR: begin
        mod_write_d = 1'b0;
        res_valid_d = 1'b1;
        res_id_d    = exec_id_q;
        res_rd_d    = exec_rd_q;
        res_we_d    = 1'b0;
        res_exc_d   = 1'b0;
        res_data_d  = '0;
        state_d     = RESP;
      end
      WAIT_ADD, WAIT_SUB: begin
        // Finish of the active unit has priority over the watchdog on the same edge.
        if ((state_q == WAIT_ADD) ? add_finish_i : sub_finish_i) begin
          add_start_d = 1'b0;
          sub_start_d = 1'b0;
          res_valid_d = 1'b1;
          res_id_d    = exec_id_q;
          res_rd_d    = exec_rd_q;
          res_we_d    = 1'b1;
          res_exc_d   = 1'b0;
          res_data_d  = (state_q == WAIT_ADD) ? add_result_i : sub_result_i;
          state_d     = RESP;
        end else if (wd_q == WW'(TIMEOUT - 1)) begin
          add_start_d = 1'b0;
          sub_start_d = 1'b0;
          res_valid_d = 1'b1;
          res_id_d    = exec_id_q;
          res_rd_d    = exec_rd_q;
          res_we_d    = 1'b0;
          res_exc_d   = 1'b1;
          res_data_d  = '0;
          state_d     = RESP;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      RESP: begin
        if (result_ready_i) begin
          res_valid_d = 1'b0;
          wd_d        = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      wd_q        <= '0;
      exec_id_q   <= '0;
      exec_rd_q   <= '0;
      add_start_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      sub_start_q <= 1'b0;
      sub_a_q     <= '0;
      sub_b_q     <= '0;
      mod_write_q <= 1'b0;
      mod_value_q <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_rd_q    <= '0;
      res_we_q    <= 1'b0;
      res_exc_q   <= 1'b0;
      res_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      wd_q        <= wd_d;
      exec_id_q   <= exec_id_d;
      exec_rd_q   <= exec_rd_d;
      add_start_q <= add_start_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      sub_start_q <= sub_start_d;
      sub_a_q     <= sub_a_d;
      sub_b_q     <= sub_b_d;
      mod_write_q <= mod_write_d;
      mod_value_q <= mod_value_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_rd_q    <= res_rd_d;
      res_we_q    <= res_we_d;
      res_exc_q   <= res_exc_d;
      res_data_q  <= res_data_d;
    end
  end

  assign add_start_o    = add_start_q;
  assign add_a_o        = add_a_q;
  assign add_b_o        = add_b_q;
  assign sub_start_o    = sub_start_q;
  assign sub_a_o        = sub_a_q;
  assign sub_b_o        = sub_b_q;
  assign mod_write_o    = mod_write_q;
  assign mod_value_o    = mod_value_q;
  assign result_valid_o = res_valid_q;
  assign result_id_o    = res_id_q;
  assign result_rd_o    = res_rd_q;
  assign result_we_o    = res_we_q;
  assign result_exc_o   = res_exc_q;
  assign result_data_o  = res_data_q;

endmodule

// File: tb/tb_ecc_op_scheduler.sv
// Directed bench for ecc_op_scheduler: ADD, MOD, queue full, backpressure, watchdog, reset and unsupported ops.
// Inputs change and outputs are sampled on the falling edge.
module tb_ecc_op_scheduler;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        issue_valid_i, issue_ready_o;
  logic [3:0]  issue_id_i;
  logic [2:0]  issue_funct3_i;
  logic [4:0]  issue_rd_i;
  logic [63:0] issue_rs1_i, issue_rs2_i;
  logic        add_start_o, add_finish_i;
  logic [63:0] add_a_o, add_b_o, add_result_i;
  logic        sub_start_o, sub_finish_i;
  logic [63:0] sub_a_o, sub_b_o, sub_result_i;
  logic        mod_write_o;
  logic [63:0] mod_value_o;
  logic        result_valid_o, result_ready_i;
  logic [3:0]  result_id_o;
  logic [4:0]  result_rd_o;
  logic        result_we_o, result_exc_o;
  logic [63:0] result_data_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ecc_op_scheduler #(.DEPTH(4), .ID_WIDTH(4), .DATA_WIDTH(64), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o), .issue_id_i(issue_id_i),
    .issue_funct3_i(issue_funct3_i), .issue_rd_i(issue_rd_i),
    .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
    .add_start_o(add_start_o), .add_a_o(add_a_o), .add_b_o(add_b_o),
    .add_finish_i(add_finish_i), .add_result_i(add_result_i),
    .sub_start_o(sub_start_o), .sub_a_o(sub_a_o), .sub_b_o(sub_b_o),
    .sub_finish_i(sub_finish_i), .sub_result_i(sub_result_i),
    .mod_write_o(mod_write_o), .mod_value_o(mod_value_o),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_rd_o(result_rd_o), .result_we_o(result_we_o),
    .result_exc_o(result_exc_o), .result_data_o(result_data_o), .busy_o(busy_o)
  );

  task automatic set_issue(input logic [3:0] id, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [63:0] a, input logic [63:0] b);
    issue_valid_i = 1'b1; issue_id_i = id; issue_funct3_i = f3;
    issue_rd_i = rd; issue_rs1_i = a; issue_rs2_i = b;
    $display("issue id=%0d funct3=%0b rd=%0d rs1=%0h rs2=%0h", id, f3, rd, a, b);
  endtask

  // Acts as both arithmetic units until a result is offered; bounded.
  task automatic wait_result(output bit timed_out);
    int n = 0;
    while (!result_valid_o && n < 50) begin
      add_finish_i = add_start_o; add_result_i = add_a_o + add_b_o;
      sub_finish_i = sub_start_o; sub_result_i = sub_a_o - sub_b_o;
      @(negedge clk);
      n++;
    end
    add_finish_i = 1'b0; sub_finish_i = 1'b0;
    timed_out = !result_valid_o;
    $display("result id=%0d rd=%0d we=%0b exc=%0b data=%0h", result_id_o, result_rd_o,
             result_we_o, result_exc_o, result_data_o);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", issue_ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy_o); end
    checks++; if ({add_start_o, sub_start_o, mod_write_o, result_valid_o} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes: got %b want 0000", {add_start_o, sub_start_o, mod_write_o, result_valid_o}); end
    checks++; if ((add_a_o | sub_b_o | mod_value_o | result_data_o) !== 64'd0) begin
      errors++; $display("FAIL reset_payload: got %0h want 0", add_a_o | sub_b_o | mod_value_o | result_data_o); end
  endtask

  task automatic test_add();
    result_ready_i = 1'b1;
    set_issue(4'd3, 3'b001, 5'd5, 64'd10, 64'd7);
    @(negedge clk);  // after E0
    issue_valid_i = 1'b0;
    checks++; if (add_start_o !== 1'b0) begin errors++; $display("FAIL add_start_e0: got %0b want 0", add_start_o); end
    @(negedge clk);  // after E1
    checks++; if ({add_start_o, add_a_o, add_b_o} !== {1'b1, 64'd10, 64'd7}) begin
      errors++; $display("FAIL add_dispatch: got start=%0b a=%0d b=%0d want 1 10 7", add_start_o, add_a_o, add_b_o); end
    @(negedge clk);
    @(negedge clk);  // after E3
    checks++; if (add_start_o !== 1'b1) begin errors++; $display("FAIL add_start_held: got %0b want 1", add_start_o); end
    add_finish_i = 1'b1; add_result_i = 64'd17;
    @(negedge clk);  // after E4
    add_finish_i = 1'b0;
    checks++; if (add_start_o !== 1'b0) begin errors++; $display("FAIL add_start_drop: got %0b want 0", add_start_o); end
    checks++; if ({result_valid_o, result_id_o, result_rd_o, result_we_o, result_exc_o, result_data_o}
                  !== {1'b1, 4'd3, 5'd5, 1'b1, 1'b0, 64'd17}) begin
      errors++; $display("FAIL add_result: got v=%0b id=%0d rd=%0d we=%0b exc=%0b data=%0d want 1 3 5 1 0 17",
                         result_valid_o, result_id_o, result_rd_o, result_we_o, result_exc_o, result_data_o); end
    @(negedge clk);
    checks++; if ({result_valid_o, busy_o} !== 2'b00) begin
      errors++; $display("FAIL add_retire: got valid=%0b busy=%0b want 0 0", result_valid_o, busy_o); end
  endtask

  task automatic test_mod();
    result_ready_i = 1'b1;
    set_issue(4'd1, 3'b000, 5'd2, 64'hFFFF_FFFF_0000_0001, 64'd0);
    @(negedge clk);
    issue_valid_i = 1'b0;
    checks++; if (mod_write_o !== 1'b0) begin errors++; $display("FAIL mod_early: got %0b want 0", mod_write_o); end
    @(negedge clk);  // after E1
    checks++; if ({mod_write_o, mod_value_o} !== {1'b1, 64'hFFFF_FFFF_0000_0001}) begin
      errors++; $display("FAIL mod_strobe: got w=%0b v=%0h want 1 ffffffff00000001", mod_write_o, mod_value_o); end
    checks++; if ({add_start_o, sub_start_o} !== 2'b00) begin
      errors++; $display("FAIL mod_no_unit: got %b want 00", {add_start_o, sub_start_o}); end
    @(negedge clk);  // after E2
    checks++; if ({mod_write_o, result_valid_o, result_id_o, result_rd_o, result_we_o, result_data_o}
                  !== {1'b0, 1'b1, 4'd1, 5'd2, 1'b0, 64'd0}) begin
      errors++; $display("FAIL mod_result: got w=%0b v=%0b id=%0d rd=%0d we=%0b data=%0h want 0 1 1 2 0 0",
                         mod_write_o, result_valid_o, result_id_o, result_rd_o, result_we_o, result_data_o); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [3:0]  exp_id [5]   = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    logic [2:0]  f3     [5]   = '{3'b001, 3'b010, 3'b000, 3'b001, 3'b010};
    logic [63:0] op_a   [5]   = '{64'd1, 64'd9, 64'd77, 64'd100, 64'd5};
    logic [63:0] op_b   [5]   = '{64'd2, 64'd4, 64'd0, 64'd23, 64'd6};
    logic        exp_we [5]   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [63:0] exp_d  [5]   = '{64'd3, 64'd5, 64'd0, 64'd123, 64'hFFFF_FFFF_FFFF_FFFF};
    int n = 0, cyc = 0, seen_at_ready = -1;
    result_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %0b want 1", i, issue_ready_o); end
      set_issue(exp_id[i], f3[i], 5'(i + 1), op_a[i], op_b[i]);
      @(negedge clk);
    end
    issue_valid_i = 1'b0;
    checks++; if (issue_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_full: got %0b want 0", issue_ready_o); end
    while (n < 5 && cyc < 200) begin
      if (seen_at_ready < 0 && issue_ready_o) seen_at_ready = n;
      if (result_valid_o) begin
        $display("result id=%0d we=%0b data=%0h", result_id_o, result_we_o, result_data_o);
        checks++; if ({result_id_o, result_we_o, result_exc_o, result_data_o} !== {exp_id[n], exp_we[n], 1'b0, exp_d[n]}) begin
          errors++; $display("FAIL b2b_result_%0d: got id=%0d we=%0b exc=%0b data=%0h want %0d %0b 0 %0h",
                             n, result_id_o, result_we_o, result_exc_o, result_data_o, exp_id[n], exp_we[n], exp_d[n]); end
        n++;
      end
      add_finish_i = add_start_o; add_result_i = add_a_o + add_b_o;
      sub_finish_i = sub_start_o; sub_result_i = sub_a_o - sub_b_o;
      @(negedge clk);
      cyc++;
    end
    add_finish_i = 1'b0; sub_finish_i = 1'b0;
    checks++; if (n !== 5) begin errors++; $display("FAIL b2b_count: got %0d want 5", n); end
    checks++; if (seen_at_ready !== 1) begin errors++; $display("FAIL b2b_ready_return: got %0d want 1", seen_at_ready); end
  endtask

  task automatic test_backpressure();
    bit to;
    int bad = 0, disp = 0;
    result_ready_i = 1'b0;
    set_issue(4'd9, 3'b010, 5'd3, 64'd5, 64'd3);
    @(negedge clk);
    set_issue(4'd10, 3'b001, 5'd4, 64'd1, 64'd1);
    @(negedge clk);
    issue_valid_i = 1'b0;
    wait_result(to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL bp_timeout: got %0b want 0", to); end
    for (int i = 0; i < 10; i++) begin
      if ({result_valid_o, result_id_o, result_rd_o, result_we_o, result_exc_o, result_data_o}
          !== {1'b1, 4'd9, 5'd3, 1'b1, 1'b0, 64'd2}) bad++;
      if (add_start_o || sub_start_o) disp++;
      @(negedge clk);
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles want 0", bad); end
    checks++; if (disp !== 0) begin errors++; $display("FAIL bp_no_dispatch: got %0d want 0", disp); end
    result_ready_i = 1'b1;
    @(negedge clk);
    checks++; if ({result_valid_o, add_start_o} !== 2'b00) begin
      errors++; $display("FAIL bp_bubble: got valid=%0b start=%0b want 0 0", result_valid_o, add_start_o); end
    @(negedge clk);
    checks++; if (add_start_o !== 1'b1) begin errors++; $display("FAIL bp_next_dispatch: got %0b want 1", add_start_o); end
    wait_result(to);
    checks++; if ({to, result_id_o, result_data_o} !== {1'b0, 4'd10, 64'd2}) begin
      errors++; $display("FAIL bp_second: got to=%0b id=%0d data=%0h want 0 10 2", to, result_id_o, result_data_o); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bit to;
    int cnt = 0, bad = 0;
    result_ready_i = 1'b1;
    set_issue(4'd11, 3'b001, 5'd6, 64'd1, 64'd2);
    @(negedge clk);
    set_issue(4'd12, 3'b010, 5'd7, 64'd8, 64'd3);
    @(negedge clk);  // after E1
    issue_valid_i = 1'b0;
    while (add_start_o && cnt < 20) begin
      cnt++;
      if (sub_start_o) bad++;
      sub_finish_i = (cnt == 3);  // stray finish from the idle unit
      sub_result_i = 64'hDEAD;
      @(negedge clk);
    end
    sub_finish_i = 1'b0;
    checks++; if (cnt !== 8) begin errors++; $display("FAIL to_start_cycles: got %0d want 8", cnt); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL to_sub_start: got %0d want 0", bad); end
    checks++; if ({result_valid_o, result_id_o, result_we_o, result_exc_o, result_data_o}
                  !== {1'b1, 4'd11, 1'b0, 1'b1, 64'd0}) begin
      errors++; $display("FAIL to_result: got v=%0b id=%0d we=%0b exc=%0b data=%0h want 1 11 0 1 0",
                         result_valid_o, result_id_o, result_we_o, result_exc_o, result_data_o); end
    @(negedge clk);
    wait_result(to);
    checks++; if ({to, result_id_o, result_we_o, result_exc_o, result_data_o} !== {1'b0, 4'd12, 1'b1, 1'b0, 64'd5}) begin
      errors++; $display("FAIL to_next_sub: got to=%0b id=%0d we=%0b exc=%0b data=%0h want 0 12 1 0 5",
                         to, result_id_o, result_we_o, result_exc_o, result_data_o); end
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    bit to;
    int stray = 0;
    result_ready_i = 1'b1;
    set_issue(4'd13, 3'b010, 5'd1, 64'd20, 64'd1);
    @(negedge clk);
    set_issue(4'd14, 3'b001, 5'd2, 64'd1, 64'd1);
    @(negedge clk);
    set_issue(4'd15, 3'b001, 5'd3, 64'd2, 64'd2);
    @(negedge clk);  // after E2: SUB in flight, two queued
    issue_valid_i = 1'b0;
    checks++; if (sub_start_o !== 1'b1) begin errors++; $display("FAIL rst_pre_sub: got %0b want 1", sub_start_o); end
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    checks++; if ({add_start_o, sub_start_o, result_valid_o, busy_o, issue_ready_o} !== 5'b00001) begin
      errors++; $display("FAIL rst_midop: got %b want 00001", {add_start_o, sub_start_o, result_valid_o, busy_o, issue_ready_o}); end
    for (int i = 0; i < 20; i++) begin
      if (result_valid_o || add_start_o || sub_start_o || mod_write_o) stray++;
      @(negedge clk);
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL rst_stale: got %0d active cycles want 0", stray); end
    set_issue(4'd2, 3'b111, 5'd7, 64'd99, 64'd98);
    @(negedge clk);
    issue_valid_i = 1'b0;
    wait_result(to);
    checks++; if ({to, result_id_o, result_rd_o, result_we_o, result_exc_o, result_data_o}
                  !== {1'b0, 4'd2, 5'd7, 1'b0, 1'b0, 64'd0}) begin
      errors++; $display("FAIL unsupported: got to=%0b id=%0d rd=%0d we=%0b exc=%0b data=%0h want 0 2 7 0 0 0",
                         to, result_id_o, result_rd_o, result_we_o, result_exc_o, result_data_o); end
    @(negedge clk);
  endtask

  initial begin
    rst_i = 1'b1; issue_valid_i = 1'b0; issue_id_i = '0; issue_funct3_i = '0; issue_rd_i = '0;
    issue_rs1_i = '0; issue_rs2_i = '0; add_finish_i = 1'b0; add_result_i = '0;
    sub_finish_i = 1'b0; sub_result_i = '0; result_ready_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_add();
    test_mod();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
